// File: rtl/keccak_pkg.sv
// Shared Keccak-f[1600] types and constants used across the permutation datapath.
package keccak_pkg;
  localparam int LANE_W_DEF = 64;
  localparam int NX         = 5;
  localparam int NY         = 5;

  typedef logic [0:LANE_W_DEF-1] lane_t;
  typedef lane_t [0:NX-1]        plane_t;
  typedef plane_t [0:NY-1]       state_t;
endpackage

// File: rtl/theta_parity.sv
// Column parity for theta: C[x][z] = XOR over all rows y of A[y][x][z].
module theta_parity
  import keccak_pkg::*;
#(
  parameter int LANE_W = LANE_W_DEF
) (
  input  logic [0:NY-1][0:NX-1][0:LANE_W-1] a,
  output logic [0:NX-1][0:LANE_W-1]         c
);

  for (genvar x = 0; x < NX; x++) begin : g_col
    assign c[x] = a[0][x] ^ a[1][x] ^ a[2][x] ^ a[3][x] ^ a[4][x];
  end

endmodule

// File: rtl/keccak_theta_stage.sv
// Two-stage registered theta step (parity register, then output register) with valid/ready.
// Optional THETA_BYPASS_EN adds bypass_i: a flagged state passes through untransformed.
module keccak_theta_stage
  import keccak_pkg::*;
#(
  parameter int LANE_W = LANE_W_DEF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [0:NY-1][0:NX-1][0:LANE_W-1] in_state,
`ifdef THETA_BYPASS_EN
  input  logic                              bypass_i,
`endif
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [0:NY-1][0:NX-1][0:LANE_W-1] out_state
);

  logic                              s1_valid, s2_valid, s2_adv, in_acc, s1_byp;
  logic [0:NY-1][0:NX-1][0:LANE_W-1] s1_state, theta;
  logic [0:NX-1][0:LANE_W-1]         par_c, s1_par, d;

  assign s2_adv    = s1_valid && (!s2_valid || out_ready);
  assign in_ready  = !s1_valid || s2_adv;
  assign in_acc    = in_valid && in_ready;
  assign out_valid = s2_valid;

  theta_parity #(.LANE_W(LANE_W)) u_parity (
    .a (in_state),
    .c (par_c)
  );

  // D[x] = C[x-1] ^ rot(C[x+1], 1); the rotate moves bit z-1 into z, wrapping LANE_W-1 into 0
  for (genvar x = 0; x < NX; x++) begin : g_d
    assign d[x] = s1_par[(x + NX - 1) % NX]
                ^ {s1_par[(x + 1) % NX][LANE_W-1], s1_par[(x + 1) % NX][0:LANE_W-2]};
    for (genvar y = 0; y < NY; y++) begin : g_row
      assign theta[y][x] = s1_state[y][x] ^ (s1_byp ? '0 : d[x]);
    end
  end

`ifdef THETA_BYPASS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      s1_byp <= 1'b0;
    else if (in_acc) s1_byp <= bypass_i;
  end
`else
  assign s1_byp = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_state <= '0;
      s1_par   <= '0;
    end else if (in_acc) begin
      s1_valid <= 1'b1;
      s1_state <= in_state;
      s1_par   <= par_c;
    end else if (s2_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      out_state <= '0;
    end else if (s2_adv) begin
      s2_valid  <= 1'b1;
      out_state <= theta;
    end else if (out_valid && out_ready) begin
      s2_valid  <= 1'b0;
    end
  end

endmodule
